// File: rtl/ws2812_input.sv
// ws2812_input: receive-side WS2812 decoder. Synchronises din, measures high
// pulses into bits (MSB first), emits one byte per data_valid strobe, and flags
// the inter-frame latch gap and malformed pulses.
// Optional build macro WS2812_INPUT_FILTER_EN adds a 3-sample majority filter
// after the synchronizer (rejects 1-cycle glitches, +1 cycle latency).
module ws2812_input #(
    parameter int unsigned BIT_THRESHOLD = 7,
    parameter int unsigned MAX_HIGH      = 24,
    parameter int unsigned RESET_CYCLES  = 600
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        din,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic [15:0] byte_index,
    output logic        latch,
    output logic        error
);

    localparam int unsigned LW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned HW = $clog2(MAX_HIGH + 2);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t        state, state_nx;
    logic [LW-1:0] low_cnt, low_cnt_nx;
    logic [HW-1:0] high_cnt, high_cnt_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          byte_c, latch_c, err_c;
    logic          byte_p, latch_p, err_p;
    logic [7:0]    byte_q;
    logic          din_m, din_r;
    logic          din_s;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge CLK) begin
        if (rst) begin
            din_m <= 1'b0;
            din_r <= 1'b0;
        end else begin
            din_m <= din;
            din_r <= din_m;
        end
    end

`ifdef WS2812_INPUT_FILTER_EN
    logic din_r1, din_r2;

    // Sample history for the majority vote
    always_ff @(posedge CLK) begin
        if (rst) begin
            din_r1 <= 1'b0;
            din_r2 <= 1'b0;
        end else begin
            din_r1 <= din_r;
            din_r2 <= din_r1;
        end
    end

    assign din_s = (din_r & din_r1) | (din_r & din_r2) | (din_r1 & din_r2);
`else
    assign din_s = din_r;
`endif

    // Decoder state register
    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= SYNC;
            low_cnt  <= '0;
            high_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            low_cnt  <= low_cnt_nx;
            high_cnt <= high_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
        end
    end

    // Next-state logic: pulse measurement, bit shifting, gap detection
    always_comb begin
        state_nx    = state;
        low_cnt_nx  = low_cnt;
        high_cnt_nx = high_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        byte_c      = 1'b0;
        latch_c     = 1'b0;
        err_c       = 1'b0;
        case (state)
            SYNC: begin
                bit_cnt_nx  = '0;
                high_cnt_nx = '0;
                if (din_s) begin
                    low_cnt_nx = '0;
                end else if (low_cnt == LW'(RESET_CYCLES - 1)) begin
                    low_cnt_nx = '0;
                    state_nx   = IDLE;
                end else begin
                    low_cnt_nx = low_cnt + LW'(1);
                end
            end
            IDLE: begin
                bit_cnt_nx = '0;
                low_cnt_nx = '0;
                if (din_s) begin
                    high_cnt_nx = HW'(1);
                    state_nx    = HIGH;
                end
            end
            HIGH: begin
                if (din_s) begin
                    if (high_cnt >= HW'(MAX_HIGH)) begin
                        // Pulse too long: drop the partial byte and resync
                        err_c       = 1'b1;
                        high_cnt_nx = '0;
                        low_cnt_nx  = '0;
                        bit_cnt_nx  = '0;
                        state_nx    = SYNC;
                    end else begin
                        high_cnt_nx = high_cnt + HW'(1);
                    end
                end else begin
                    shreg_nx   = {shreg[6:0], (high_cnt >= HW'(BIT_THRESHOLD))};
                    bit_cnt_nx = bit_cnt + 3'(1);
                    byte_c     = (bit_cnt == 3'd7);
                    low_cnt_nx = LW'(1);
                    state_nx   = LOW;
                end
            end
            LOW: begin
                if (din_s) begin
                    high_cnt_nx = HW'(1);
                    low_cnt_nx  = '0;
                    state_nx    = HIGH;
                end else if (low_cnt == LW'(RESET_CYCLES - 1)) begin
                    // End of frame; a partially received byte is malformed
                    latch_c    = 1'b1;
                    err_c      = (bit_cnt != 3'd0);
                    bit_cnt_nx = '0;
                    low_cnt_nx = '0;
                    state_nx   = IDLE;
                end else begin
                    low_cnt_nx = low_cnt + LW'(1);
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    // Event stage: capture completed byte and strobes
    always_ff @(posedge CLK) begin
        if (rst) begin
            byte_p  <= 1'b0;
            latch_p <= 1'b0;
            err_p   <= 1'b0;
            byte_q  <= '0;
        end else begin
            byte_p  <= byte_c;
            latch_p <= latch_c;
            err_p   <= err_c;
            if (byte_c) begin
                byte_q <= shreg_nx;
            end
        end
    end

    // Output registers; byte_index advances after each delivered byte
    always_ff @(posedge CLK) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            byte_index <= '0;
            latch      <= 1'b0;
            error      <= 1'b0;
        end else begin
            data_valid <= byte_p;
            latch      <= latch_p;
            error      <= err_p;
            if (byte_p) begin
                data <= byte_q;
            end
            if (latch_p || err_p) begin
                byte_index <= '0;
            end else if (data_valid) begin
                byte_index <= byte_index + 16'(1);
            end
        end
    end

endmodule

// File: tb/tb_ws2812_input.sv
// tb_ws2812_input: directed, table-driven bench for the WS2812 receive decoder.
module tb_ws2812_input;

`ifdef WS2812_INPUT_FILTER_EN
    localparam int F = 1;
`else
    localparam int F = 0;
`endif
    localparam int RC = 600;

    logic        CLK;
    logic        rst;
    logic        din;
    logic [7:0]  data;
    logic        data_valid;
    logic [15:0] byte_index;
    logic        latch;
    logic        error;

    ws2812_input dut (
        .CLK        (CLK),
        .rst        (rst),
        .din        (din),
        .data       (data),
        .data_valid (data_valid),
        .byte_index (byte_index),
        .latch      (latch),
        .error      (error)
    );

    typedef struct {
        int          nbits;
        logic [23:0] payload;
        int          hi1, lo1, hi0, lo0;
        int          exp_n;
        logic [23:0] exp_b;
        int          exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_fall;
    int rise_edge;

    int         fall_q[$];
    int         dv_cyc[$];
    logic [7:0] dv_data[$];
    int         dv_idx[$];
    int         latch_cyc[$];
    int         err_cyc[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge counter used to timestamp events
    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (!rst) begin
            if (data_valid) begin
                dv_cyc.push_back(cyc);
                dv_data.push_back(data);
                dv_idx.push_back(int'(byte_index));
            end
            if (latch) latch_cyc.push_back(cyc);
            if (error) err_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_ev();
        fall_q.delete();
        dv_cyc.delete();
        dv_data.delete();
        dv_idx.delete();
        latch_cyc.delete();
        err_cyc.delete();
    endtask

    // Hold din at a level for n cycles (called at a falling edge)
    task automatic drive(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input int nbits, input logic [23:0] payload,
                              input int hi1, input int lo1, input int hi0,
                              input int lo0, input int gap);
        logic b;
        for (int i = nbits - 1; i >= 0; i--) begin
            b = payload[i];
            drive(1'b1, b ? hi1 : hi0);
            last_fall = cyc + 1;
            if (((nbits - 1 - i) % 8) == 7) fall_q.push_back(last_fall);
            drive(1'b0, b ? lo1 : lo0);
        end
        drive(1'b0, gap);
    endtask

    // Compare a single decoded byte including its strobe timing
    task automatic chk_byte(input string nm, input int j, input logic [7:0] eb);
        chk({nm, " data"}, (j < dv_data.size()) ? int'(dv_data[j]) : -1, int'(eb));
        chk({nm, " idx"}, (j < dv_idx.size()) ? dv_idx[j] : -1, j);
        chk({nm, " dv_cyc"}, (j < dv_cyc.size()) ? dv_cyc[j] : -1,
            (j < fall_q.size()) ? fall_q[j] + 3 + F : -2);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{24, 24'h1234AB, 10, 5, 4, 11,   3, 24'h1234AB, 0};
        vecs[1] = '{12, 24'h000A5C, 10, 5, 4, 11,   1, 24'hA50000, 1};
        vecs[2] = '{16, 24'h00F00F,  7, 5, 6, 5,    2, 24'hF00F00, 0};
        vecs[3] = '{8,  24'h0000C3, 24, 5, 4, 11,   1, 24'hC30000, 0};
        vecs[4] = '{8,  24'h00005A, 10, 599, 4, 599, 1, 24'h5A0000, 0};
        vecs[5] = '{20, 24'h0FFFFF, 10, 5, 4, 11,   2, 24'hFFFF00, 1};

        din = 1'b0;
        rst = 1'b1;
        @(negedge CLK);
        repeat (3) @(negedge CLK);
        chk("reset data", int'(data), 0);
        chk("reset data_valid", int'(data_valid), 0);
        chk("reset byte_index", int'(byte_index), 0);
        chk("reset latch", int'(latch), 0);
        chk("reset error", int'(error), 0);

        // Line high out of reset: nothing decodes until a full gap is seen
        din = 1'b1;
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        drive(1'b1, 100);
        clear_ev();
        send_frame(8, 24'h0000A5, 10, 5, 4, 11, 0);
        drive(1'b0, RC + 20);
        chk("sync dv", dv_data.size(), 0);
        chk("sync latch", latch_cyc.size(), 0);
        chk("sync err", err_cyc.size(), 0);
        clear_ev();
        send_frame(8, 24'h00003C, 10, 5, 4, 11, RC + 20);
        chk("post-sync n", dv_data.size(), 1);
        chk_byte("post-sync b0", 0, 8'h3C);
        chk("post-sync latch", latch_cyc.size(), 1);
        chk("post-sync err", err_cyc.size(), 0);

        // Table-driven frames, each followed by a latch gap
        for (int v = 0; v < 6; v++) begin
            clear_ev();
            send_frame(vecs[v].nbits, vecs[v].payload, vecs[v].hi1, vecs[v].lo1,
                       vecs[v].hi0, vecs[v].lo0, RC + 20);
            chk($sformatf("v%0d n", v), dv_data.size(), vecs[v].exp_n);
            for (int j = 0; j < vecs[v].exp_n; j++)
                chk_byte($sformatf("v%0d b%0d", v, j), j, vecs[v].exp_b[23 - 8*j -: 8]);
            chk($sformatf("v%0d latch n", v), latch_cyc.size(), 1);
            chk($sformatf("v%0d latch cyc", v),
                (latch_cyc.size() > 0) ? latch_cyc[0] : -1, last_fall + 2 + RC + F);
            chk($sformatf("v%0d err n", v), err_cyc.size(), vecs[v].exp_err);
            if (vecs[v].exp_err != 0)
                chk($sformatf("v%0d err cyc", v),
                    (err_cyc.size() > 0) ? err_cyc[0] : -1, last_fall + 2 + RC + F);
            chk($sformatf("v%0d data hold", v), int'(data),
                int'(vecs[v].exp_b[23 - 8*(vecs[v].exp_n - 1) -: 8]));
        end

        // Over-long high pulse mid-byte
        clear_ev();
        send_frame(3, 24'h000005, 10, 5, 4, 11, 0);
        rise_edge = cyc + 1;
        drive(1'b1, 25);
        drive(1'b0, 5);
        send_frame(8, 24'h0000FF, 10, 5, 4, 11, RC + 20);
        chk("long err n", err_cyc.size(), 1);
        chk("long err cyc", (err_cyc.size() > 0) ? err_cyc[0] : -1, rise_edge + 27 + F);
        chk("long dv", dv_data.size(), 0);
        chk("long latch", latch_cyc.size(), 0);
        clear_ev();
        send_frame(8, 24'h00005A, 10, 5, 4, 11, RC + 20);
        chk("recover n", dv_data.size(), 1);
        chk_byte("recover b0", 0, 8'h5A);
        chk("recover latch", latch_cyc.size(), 1);
        chk("recover err", err_cyc.size(), 0);

        // Single-cycle glitch in the idle gap
        clear_ev();
        drive(1'b0, 10);
        drive(1'b1, 1);
        drive(1'b0, RC + 20);
        chk("glitch dv", dv_data.size(), 0);
        chk("glitch latch", latch_cyc.size(), 1 - F);
        chk("glitch err", err_cyc.size(), 1 - F);

        // Reset mid-frame after one byte
        clear_ev();
        send_frame(11, 24'h0002D3, 10, 5, 4, 11, 0);
        chk("midrst pre idx", int'(byte_index), 1);
        chk("midrst pre data", int'(data), 8'h5A);
        rst = 1'b1;
        repeat (3) @(negedge CLK);
        chk("midrst idx", int'(byte_index), 0);
        chk("midrst data", int'(data), 0);
        chk("midrst dv", int'(data_valid), 0);
        rst = 1'b0;
        drive(1'b0, RC + 20);
        clear_ev();
        send_frame(8, 24'h000081, 10, 5, 4, 11, RC + 20);
        chk("midrst next n", dv_data.size(), 1);
        chk_byte("midrst next b0", 0, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_input.md
# ws2812_input

Receive-side decoder for the single-wire WS2812 LED protocol, the counterpart of our `ws2812_output` transmitter. It samples the asynchronous serial line, measures each high pulse to recover bits (MSB first, 24 bits per LED in G-R-B byte order as sent), and presents one byte at a time with a one-cycle strobe. It also flags the inter-frame reset gap (latch) and malformed pulses. It is used for loopback verification of the fader chain and as the front end of a chained/pass-through LED node.

## Interface
- `BIT_THRESHOLD`, 7: a high pulse of at least this many CLK cycles decodes as 1; shorter decodes as 0 (0.58 µs at 12 MHz).
- `MAX_HIGH`, 24: a high pulse longer than this many cycles is a protocol error.
- `RESET_CYCLES`, 600: continuous low cycles that constitute a reset/latch gap (50 µs at 12 MHz).
- Legal only if 1 ≤ `BIT_THRESHOLD` ≤ `MAX_HIGH` < `RESET_CYCLES`.

- `CLK` in 1: clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `din` in 1: asynchronous WS2812 serial line.
- `data` out 8: last completed byte; holds until the next byte completes.
- `data_valid` out 1: one-cycle strobe, `data`/`byte_index` valid.
- `byte_index` out 16: index of the byte in `data` within the current frame (0 = first).
- `latch` out 1: one-cycle strobe at the end of a reset gap following frame data.
- `error` out 1: one-cycle strobe on malformed input.

## Operation
- Front end: `din` → 2-flop synchronizer → `din_s` (optionally filtered, see Configuration). All decoding uses `din_s`.
- States: SYNC, IDLE, HIGH, LOW.
- SYNC (after reset or error): count consecutive low cycles; any high clears the count. At `RESET_CYCLES` → IDLE, no `latch` strobe.
- IDLE: on `din_s` = 1 → HIGH; bit counter and `byte_index` are 0.
- HIGH: high counter increments each cycle `din_s` = 1 (saturating at `MAX_HIGH`+1). When it exceeds `MAX_HIGH`: `error` strobe, partial byte discarded, → SYNC. On `din_s` = 0: shift bit (count ≥ `BIT_THRESHOLD`) into the shift register, → LOW. On the 8th bit: `data` ← byte, `data_valid` strobe, bit counter → 0.
- `byte_index` increments on the cycle after each `data_valid`; it wraps 0xFFFF→0.
- LOW: low counter counts cycles of `din_s` = 0. On `din_s` = 1 before `RESET_CYCLES` → HIGH (next bit, same frame). On reaching `RESET_CYCLES`: `latch` strobe, `byte_index` ← 0, → IDLE. If bits 1–7 of a byte are pending, they are discarded and `error` strobes in the same cycle as `latch`.
- High pulse count N equals `din` high duration in cycles exactly; the synchronizer only delays.
- `data_valid` and `latch` never coincide (a latch needs `RESET_CYCLES` of low).
- Reset mid-frame: all state discarded, outputs return to reset values, → SYNC.

## Timing
- Reset values: `data` 0, `data_valid` 0, `byte_index` 0, `latch` 0, `error` 0; state SYNC.
- Latency without filter: if edge k is the first to sample the 8th bit's falling `din`, `data_valid` is high in the cycle after edge k+3.
- `latch` is high in the cycle after edge k+2+`RESET_CYCLES`, where edge k is the first to sample the final falling `din`.
- Filter adds 1 cycle to every latency.
- Back-to-back bytes: `data_valid` can strobe every 8 bit periods; there is no backpressure and the consumer must take `data` within the strobe or before the next one.

## Configuration
- `WS2812_INPUT_FILTER_EN` defined: a 3-sample majority filter runs after the synchronizer. Single-cycle glitches are rejected and all latencies grow by 1 cycle. Pulse width is preserved for pulses of at least 2 cycles.
- Undefined: `din_s` is the raw 2-flop synchronizer output, and a 1-cycle glitch decodes as a short (0) bit.

## Test plan
- Reset, `din` low for 600 cycles, then 24 bits 0x12,0x34,0xAB (1 = 10 high/5 low, 0 = 4 high/11 low), then low for 600 cycles → three `data_valid` strobes with `data` 0x12/0x34/0xAB and `byte_index` 0/1/2, then one `latch`, with `error` never set.
- `din` high after reset, before any 600-cycle low → no strobes until the gap completes, then normal decoding.
- High pulse of 25 cycles mid-byte → `error` strobe at count 25, byte discarded, no `data_valid` until after a 600-cycle low gap.
- 12 bits followed by a 600-cycle gap → one `data_valid`, then `latch` and `error` in the same cycle; next frame's `byte_index` starts at 0.
- Boundary pulses: 6-cycle high decodes as 0, 7-cycle as 1, 24-cycle as 1 with no error; a low gap of 599 cycles continues the frame.
- With `WS2812_INPUT_FILTER_EN`: a 1-cycle high glitch in the gap produces no bit and no error; latencies are measured +1 against the unfiltered build.
